// File: rtl/acappella_pkg.sv
// Shared types and widths for the acappella SRAM path.
package acappella_pkg;

  localparam int unsigned SRAM_HALF_W = 16;
  localparam int unsigned SRAM_ADDR_W = 20;
  localparam int unsigned S1_ADDR_W   = 23;

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} sram_state_t;

endpackage

// File: rtl/sram_half_access.sv
// One timed halfword access on the async SRAM: phase counter, control strobes,
// DQ tri-state and a strobe marking the cycle on which read data is sampled.
module sram_half_access
  import acappella_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_active,
  input  logic                   i_write,
  input  logic                   i_enable,
  input  logic [SRAM_ADDR_W-1:0] i_addr,
  input  logic [SRAM_HALF_W-1:0] i_wdata,
  input  logic [1:0]             i_be_n,
  output logic                   o_last,
  output logic                   o_sample,
  output logic [SRAM_HALF_W-1:0] o_rdata,
  inout  logic [SRAM_HALF_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  localparam int unsigned CntW = $clog2(ACCESS_CYCLES);

  logic [CntW-1:0] r_cnt;
  logic            w_on;
  logic            w_drive;

  assign o_last   = i_active && (r_cnt == CntW'(ACCESS_CYCLES - 1));
  assign o_sample = o_last && !i_write;
  // An out-of-range access keeps the chip fully deselected.
  assign w_on     = i_active && i_enable;
  assign w_drive  = w_on && i_write;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!i_active || o_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    SRAM_ADDR = '0;
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    if (i_active) begin
      SRAM_ADDR = i_addr;
    end
    if (w_on) begin
      SRAM_CE_N = 1'b0;
      SRAM_OE_N = i_write;
      // WE_N rises on the last cycle so data stays valid past the write edge.
      SRAM_WE_N = !(i_write && !o_last);
      SRAM_UB_N = i_write ? i_be_n[1] : 1'b0;
      SRAM_LB_N = i_write ? i_be_n[0] : 1'b0;
    end
  end

  assign SRAM_DQ = w_drive ? i_wdata : 'z;
  assign o_rdata = i_enable ? SRAM_DQ : '0;

endmodule

// File: rtl/sram_s1_responder.sv
// Avalon-MM s1 slave that serves each 32-bit word as two halfword accesses
// (LO then HI) on the 16-bit asynchronous SRAM.
module sram_s1_responder
  import acappella_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [S1_ADDR_W-1:0]   s1_address,
  input  logic [3:0]             s1_byteenable_n,
  input  logic                   s1_chipselect,
  input  logic [31:0]            s1_writedata,
  input  logic                   s1_read_n,
  input  logic                   s1_write_n,
  output logic [31:0]            s1_readdata,
  output logic                   s1_readdatavalid,
  output logic                   s1_waitrequest,
  inout  logic [SRAM_HALF_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  sram_state_t            r_state, w_state_d;
  logic [S1_ADDR_W-1:0]   r_addr;
  logic [31:0]            r_wdata;
  logic [3:0]             r_be_n;
  logic                   r_write;
  logic [SRAM_HALF_W-1:0] r_rlo;
  logic [31:0]            r_readdata;

  logic                   w_req;
  logic                   w_accept;
  logic                   w_active;
  logic                   w_hi;
  logic                   w_last;
  logic                   w_sample;
  logic [SRAM_HALF_W-1:0] w_rdata;

  assign w_req    = s1_chipselect && (!s1_read_n || !s1_write_n);
  assign w_accept = (r_state == IDLE) && w_req;
  assign w_active = (r_state == LO) || (r_state == HI);
  assign w_hi     = (r_state == HI);

  assign s1_waitrequest   = (r_state != IDLE);
  assign s1_readdatavalid = (r_state == RESP);
  assign s1_readdata      = r_readdata;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE: if (w_req) w_state_d = LO;
      LO:   if (w_last) w_state_d = HI;
      HI:   if (w_last) w_state_d = r_write ? IDLE : RESP;
      RESP: w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be_n     <= '1;
      r_write    <= 1'b0;
      r_rlo      <= '0;
      r_readdata <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_addr  <= s1_address;
        r_wdata <= s1_writedata;
        r_be_n  <= s1_byteenable_n;
        // Both strobes low counts as a write.
        r_write <= !s1_write_n;
      end
      if (w_sample && !w_hi) r_rlo <= w_rdata;
      if (w_sample && w_hi) r_readdata <= {w_rdata, r_rlo};
    end
  end

  sram_half_access #(
    .ACCESS_CYCLES (ACCESS_CYCLES)
  ) u_half (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_active  (w_active),
    .i_write   (r_write),
    .i_enable  (r_addr[22:19] == 4'd0),
    .i_addr    ({r_addr[18:0], w_hi}),
    .i_wdata   (w_hi ? r_wdata[31:16] : r_wdata[15:0]),
    .i_be_n    (w_hi ? r_be_n[3:2] : r_be_n[1:0]),
    .o_last    (w_last),
    .o_sample  (w_sample),
    .o_rdata   (w_rdata),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N)
  );

endmodule

// File: tb/tb_sram_s1_responder.sv
// Directed bench for sram_s1_responder with a simple async SRAM model (A = 2).
module tb_sram_s1_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [22:0] s1_address = '0;
  logic [3:0]  s1_byteenable_n = 4'hF;
  logic        s1_chipselect = 1'b0;
  logic [31:0] s1_writedata = '0;
  logic        s1_read_n = 1'b1;
  logic        s1_write_n = 1'b1;
  logic [31:0] s1_readdata;
  logic        s1_readdatavalid;
  logic        s1_waitrequest;
  wire  [15:0] sram_dq;
  logic [19:0] sram_addr;
  logic        oe_n, we_n, ce_n, ub_n, lb_n;

  logic [15:0] mem [0:255];
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  sram_s1_responder #(
    .ACCESS_CYCLES (2)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .s1_address       (s1_address),
    .s1_byteenable_n  (s1_byteenable_n),
    .s1_chipselect    (s1_chipselect),
    .s1_writedata     (s1_writedata),
    .s1_read_n        (s1_read_n),
    .s1_write_n       (s1_write_n),
    .s1_readdata      (s1_readdata),
    .s1_readdatavalid (s1_readdatavalid),
    .s1_waitrequest   (s1_waitrequest),
    .SRAM_DQ          (sram_dq),
    .SRAM_ADDR        (sram_addr),
    .SRAM_OE_N        (oe_n),
    .SRAM_WE_N        (we_n),
    .SRAM_CE_N        (ce_n),
    .SRAM_UB_N        (ub_n),
    .SRAM_LB_N        (lb_n)
  );

  // SRAM model: weak pull-high shows an undriven bus as 16'hFFFF.
  assign (weak0, weak1) sram_dq = 16'hFFFF;
  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) mem[sram_addr[7:0]][7:0] <= sram_dq[7:0];
      if (!ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
    end
  end

  // Present a request and hold it until the responder accepts it.
  task automatic issue(input logic rd, input logic wr, input logic [22:0] addr,
                       input logic [31:0] data, input logic [3:0] ben);
    int budget = 50;
    @(negedge clk);
    s1_address = addr; s1_writedata = data; s1_byteenable_n = ben;
    s1_read_n = !rd; s1_write_n = !wr; s1_chipselect = 1'b1;
    while (s1_waitrequest && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_total++;
      $display("FAIL issue_timeout: waitrequest stuck at %b, required 0", s1_waitrequest);
    end
    @(posedge clk);
    #1;
    s1_chipselect = 1'b0; s1_read_n = 1'b1; s1_write_n = 1'b1;
  endtask

  task automatic wait_idle();
    int budget = 50;
    @(negedge clk);
    while (s1_waitrequest && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_total++;
      $display("FAIL idle_timeout: waitrequest %b, required 0", s1_waitrequest);
    end
  endtask

  // Issues a read and records first readdatavalid cycle and the pulse count.
  task automatic do_read(input logic [22:0] addr, output int first, output int cnt,
                         output logic [31:0] data);
    first = -1; cnt = 0; data = '0;
    issue(1'b1, 1'b0, addr, 32'h0, 4'h0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (s1_readdatavalid) begin
        cnt++;
        if (first < 0) begin first = c; data = s1_readdata; end
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if ({s1_waitrequest, s1_readdatavalid} !== 2'b00) $display("FAIL reset_flags: wr/rdv %b, required 00", {s1_waitrequest, s1_readdatavalid});
    else n_pass++;
    n_total++;
    if (s1_readdata !== 32'h0) $display("FAIL reset_readdata: %h, required 0", s1_readdata);
    else n_pass++;
    n_total++;
    if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'b11111) $display("FAIL reset_ctrl: %b, required 11111", {ce_n, oe_n, we_n, ub_n, lb_n});
    else n_pass++;
    n_total++;
    if (sram_addr !== 20'h0 || sram_dq !== 16'hFFFF) $display("FAIL reset_bus: addr %h dq %h, required 0 / released", sram_addr, sram_dq);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    logic [19:0] exp_a [4];
    logic        exp_we [4];
    int first, cnt;
    logic [31:0] data;
    exp_a = '{20'h20, 20'h20, 20'h21, 20'h21};
    exp_we = '{1'b0, 1'b1, 1'b0, 1'b1};
    issue(1'b0, 1'b1, 23'h10, 32'hDEADBEEF, 4'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_total++;
      if (sram_addr !== exp_a[c] || we_n !== exp_we[c] || ce_n !== 1'b0 || oe_n !== 1'b1)
        $display("FAIL write_phase%0d: addr %h we %b ce %b oe %b, required %h %b 0 1",
                 c + 1, sram_addr, we_n, ce_n, oe_n, exp_a[c], exp_we[c]);
      else n_pass++;
    end
    wait_idle();
    n_total++;
    if (mem[8'h20] !== 16'hBEEF || mem[8'h21] !== 16'hDEAD)
      $display("FAIL write_mem: %h %h, required BEEF DEAD", mem[8'h20], mem[8'h21]);
    else n_pass++;
    do_read(23'h10, first, cnt, data);
    n_total++;
    if (first !== 5 || cnt !== 1) $display("FAIL read_latency: cycle %0d count %0d, required 5 1", first, cnt);
    else n_pass++;
    n_total++;
    if (data !== 32'hDEADBEEF) $display("FAIL read_data: %h, required DEADBEEF", data);
    else n_pass++;
  endtask

  task automatic test_partial();
    int first, cnt;
    logic [31:0] data;
    issue(1'b0, 1'b1, 23'h10, 32'h11223344, 4'b1010);
    wait_idle();
    do_read(23'h10, first, cnt, data);
    n_total++;
    if (data !== 32'hDE22BE44 || cnt !== 1) $display("FAIL partial_write: %h count %0d, required DE22BE44 1", data, cnt);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    int first, cnt, ce_low;
    logic [31:0] data;
    ce_low = 0;
    fork
      begin
        issue(1'b0, 1'b1, 23'h80000, 32'h12345678, 4'h0);
        wait_idle();
        do_read(23'h80000, first, cnt, data);
      end
      begin
        for (int c = 0; c < 30; c++) begin
          @(negedge clk);
          if (!ce_n) ce_low++;
        end
      end
    join
    n_total++;
    if (ce_low !== 0) $display("FAIL oor_ce: ce_n low %0d cycles, required 0", ce_low);
    else n_pass++;
    n_total++;
    if (data !== 32'h0 || cnt !== 1) $display("FAIL oor_read: %h count %0d, required 0 1", data, cnt);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int busy, cnt;
    logic [31:0] data;
    busy = 0; cnt = 0; data = '0;
    issue(1'b0, 1'b1, 23'h11, 32'hCAFEF00D, 4'h0);
    s1_address = 23'h11; s1_read_n = 1'b0; s1_chipselect = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!s1_waitrequest) break;
      busy++;
    end
    @(posedge clk);
    #1;
    s1_chipselect = 1'b0; s1_read_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (s1_readdatavalid) begin cnt++; data = s1_readdata; end
    end
    n_total++;
    if (busy !== 4) $display("FAIL b2b_busy: %0d cycles, required 4", busy);
    else n_pass++;
    n_total++;
    if (cnt !== 1 || data !== 32'hCAFEF00D) $display("FAIL b2b_read: count %0d data %h, required 1 CAFEF00D", cnt, data);
    else n_pass++;
  endtask

  task automatic test_both_low();
    int cnt = 0;
    issue(1'b1, 1'b1, 23'h12, 32'hA5A55A5A, 4'h0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (s1_readdatavalid) cnt++;
    end
    n_total++;
    if (cnt !== 0) $display("FAIL both_low_rdv: %0d pulses, required 0", cnt);
    else n_pass++;
    n_total++;
    if (mem[8'h24] !== 16'h5A5A || mem[8'h25] !== 16'hA5A5)
      $display("FAIL both_low_mem: %h %h, required 5A5A A5A5", mem[8'h24], mem[8'h25]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    int cnt = 0, first;
    logic [31:0] data;
    issue(1'b1, 1'b0, 23'h10, 32'h0, 4'h0);
    @(negedge clk);
    n_total++;
    if (ce_n !== 1'b0 || oe_n !== 1'b0) $display("FAIL mid_read_active: ce %b oe %b, required 0 0", ce_n, oe_n);
    else n_pass++;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_total++;
    if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'b11111 || s1_waitrequest !== 1'b0)
      $display("FAIL mid_reset_ctrl: ctrl %b wr %b, required 11111 0", {ce_n, oe_n, we_n, ub_n, lb_n}, s1_waitrequest);
    else n_pass++;
    n_total++;
    if (sram_dq !== 16'hFFFF || s1_readdata !== 32'h0 || sram_addr !== 20'h0)
      $display("FAIL mid_reset_bus: dq %h rdata %h addr %h, required released 0 0", sram_dq, s1_readdata, sram_addr);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (s1_readdatavalid) cnt++;
    end
    n_total++;
    if (cnt !== 0) $display("FAIL mid_reset_rdv: %0d pulses, required 0", cnt);
    else n_pass++;
    do_read(23'h10, first, cnt, data);
    n_total++;
    if (first !== 5 || cnt !== 1 || data !== 32'hDE22BE44)
      $display("FAIL after_reset_read: cycle %0d count %0d data %h, required 5 1 DE22BE44", first, cnt, data);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    test_reset();
    test_write_read();
    test_partial();
    test_out_of_range();
    test_back_to_back();
    test_both_low();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
